instr_load_ctrl: RTL and testbench
==================================

# instr_load_ctrl

Sequences instruction loading and runtime access for the RISC-V BRAM. It consumes the byte-write stream drained from the instruction config FIFO, which is one `{addr[23:0], data[7:0]}` packet per cycle, and turns it into byte-lane writes on the BRAM write port. It shares that port with the core's store path, giving config writes priority, and holds the core in reset while a program is loaded. A reserved command address lets the host halt the core, release it, and clear the load statistics.

## Interface
- `MEM_AW`, 14: BRAM word-address width (2^MEM_AW 32-bit words).
- `CMD_ADDR`, 24'hFFFFFF: byte address decoded as the command register.
- `RST_HOLD`, 16: cycles `core_rst_n` is held low in RELEASE (≥1).
- `clk_user` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_wr_en` in 1: config byte valid. No backpressure; may be asserted every cycle.
- `cfg_addr` in 24: config byte address.
- `cfg_din` in 8: config byte data.
- `core_req` in 1: core store request.
- `core_addr` in MEM_AW: core store word address.
- `core_wdata` in 32: core store data.
- `core_wstrb` in 4: core store byte strobes.
- `core_gnt` out 1: core store accepted this cycle.
- `core_rst_n` out 1: reset to the RISC-V core, active-low.
- `mem_en` out 1: BRAM write-port enable.
- `mem_we` out 4: BRAM byte write enables.
- `mem_addr` out MEM_AW: BRAM word address.
- `mem_wdata` out 32: BRAM write data.
- `load_busy` out 1: high whenever state ≠ RUN.
- `byte_count` out 24: number of accepted config data bytes. Saturates at 24'hFFFFFF.
- `checksum` out 8: sum mod 256 of accepted config data bytes.
- `err_oor` out 1: sticky flag. Set when an out-of-range config address is seen.

## Operation
- Classification of each cycle with `cfg_wr_en`=1:
  - `cfg_addr`==CMD_ADDR: command.
  - else `cfg_addr[23:MEM_AW+2]`==0: data byte.
  - else: out-of-range. The byte is dropped and `err_oor` is set.
- Data byte writes:
  - `mem_we` = one-hot lane `1<<cfg_addr[1:0]`.
  - `mem_addr` = `cfg_addr[MEM_AW+1:2]`.
  - `mem_wdata` = `{4{cfg_din}}`.
  - `mem_en` = 1.
  - Accepted in every state.
  - Updates `byte_count` (+1, saturating) and `checksum` (+`cfg_din`, wraps).
- Commands (`cfg_din`):
  - 8'h01 HALT: from any state, go to HALT.
  - 8'h02 RUN: from HALT only, go to RELEASE. Ignored in RELEASE and RUN.
  - 8'h03 CLEAR: zero `byte_count`, `checksum` and `err_oor`. State is unchanged.
  - Any other value: ignored.
  - Commands never write the BRAM.
- States:
  - HALT (reset state): `core_rst_n`=0. The core is never granted.
  - RELEASE: `core_rst_n`=0. The hold counter counts RST_HOLD cycles, then the state moves to RUN. The counter is cleared on entry. A HALT command returns the state to HALT.
  - RUN: `core_rst_n`=1. A HALT command moves the state to HALT on the next edge.
- Arbitration:
  - `core_gnt` = `core_req` & (state==RUN) & ~`cfg_wr_en`. It is combinational.
  - Any `cfg_wr_en`, including a command or an out-of-range byte, blocks the core for that cycle.
  - On grant: `mem_we` = `core_wstrb`, `mem_addr` = `core_addr`, `mem_wdata` = `core_wdata`, `mem_en` = 1.
  - The core holds its request until granted.
- A cycle with no accepted write drives `mem_en`=0 and `mem_we`=0. `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset values:
  - State HALT.
  - `core_rst_n`=0, `load_busy`=1.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `byte_count`=0, `checksum`=0, `err_oor`=0.
  - Hold counter 0.
- Reset takes effect immediately (asynchronous assert). Asserting `reset_n` mid-load or mid-run forces HALT and holds the core in reset. Any write in flight is dropped.
- `mem_*` are registered: a write is driven on the port 1 cycle after the cycle in which it was accepted.
- `byte_count`, `checksum` and `err_oor` update on the edge after the accepting cycle.
- RUN command accepted in cycle t:
  - State is RELEASE from t+1.
  - `core_rst_n` rises at t+1+RST_HOLD.
  - `load_busy` falls in the same cycle.
- HALT command in RUN at cycle t: `core_rst_n`=0 and `core_gnt`=0 from t+1.
- A data byte and a core request in the same cycle: the data byte is written and `core_gnt`=0.
- A CLEAR command takes priority over a simultaneous count update. It can only coincide with itself, because there is one byte per cycle.

## Test plan
- Reset, then write bytes 0x11, 0x22, 0x33, 0x44 to addresses 0-3:
  - Expect `mem_we` = 1, 2, 4, 8, each at `mem_addr` 0, one cycle after each byte.
  - Expect `byte_count`=4 and `checksum`=0xAA.
  - Expect `core_rst_n`=0 throughout.
- RUN command with RST_HOLD=16:
  - `core_rst_n` rises exactly 17 cycles after the command cycle.
  - A second RUN command sent in RUN is ignored.
- In RUN, hold `core_req` with wstrb 4'hF at addr 5 while `cfg_wr_en` is high for 3 consecutive cycles:
  - `core_gnt`=0 for those 3 cycles, then 1 on the 4th.
  - `mem_*` show the 3 config bytes followed by the core word.
- HALT command sent during RELEASE and during RUN:
  - State returns to HALT and `core_rst_n`=0 the next cycle.
  - A `core_req` raised afterwards is never granted.
- Write address 24'h100000 (out of range for MEM_AW=14):
  - No `mem_en`, and `err_oor`=1.
  - A following CLEAR command zeroes `err_oor`, `byte_count` and `checksum`.
- Assert `reset_n` low for one cycle in the middle of a RUN with traffic:
  - All outputs return to their reset values asynchronously.
  - State is HALT after release.

Source files
------------

// File: rtl/instr_load_ctrl.sv
// instr_load_ctrl
// Turns the instruction-config byte stream into BRAM byte-lane writes,
// shares the BRAM write port with the core store path (config first),
// and sequences the core reset through HALT -> RELEASE -> RUN.
// A reserved command address carries HALT / RUN / CLEAR requests.

module instr_load_ctrl #(
    parameter int          MEM_AW   = 14,
    parameter logic [23:0] CMD_ADDR = 24'hFFFFFF,
    parameter int          RST_HOLD = 16
) (
    input  logic              clk_user,
    input  logic              reset_n,
    // config byte stream (no backpressure)
    input  logic              cfg_wr_en,
    input  logic [23:0]       cfg_addr,
    input  logic [7:0]        cfg_din,
    // core store path
    input  logic              core_req,
    input  logic [MEM_AW-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_wstrb,
    output logic              core_gnt,
    output logic              core_rst_n,
    // BRAM write port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    // status
    output logic              load_busy,
    output logic [23:0]       byte_count,
    output logic [7:0]        checksum,
    output logic              err_oor
);

    // Hold counter only needs to reach RST_HOLD-1.
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam int HI_W = 22 - MEM_AW;

    localparam logic [7:0] CMD_HALT  = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;

    typedef enum logic [1:0] {
        ST_HALT    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // One-hot byte lane from the low address bits.
    function automatic logic [3:0] lane_decode(input logic [1:0] sel);
        logic [3:0] lane;
        case (sel)
            2'd0:    lane = 4'b0001;
            2'd1:    lane = 4'b0010;
            2'd2:    lane = 4'b0100;
            2'd3:    lane = 4'b1000;
            default: lane = 4'b0000;
        endcase
        return lane;
    endfunction

    // Byte counter increment that sticks at all-ones.
    function automatic logic [23:0] sat_inc24(input logic [23:0] v);
        logic [23:0] res;
        if (v == 24'hFFFFFF) begin
            res = v;
        end else begin
            res = v + 24'd1;
        end
        return res;
    endfunction

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_core_rst_n;
    logic                r_load_busy;
    logic                r_mem_en;
    logic [3:0]          r_mem_we;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [23:0]         r_byte_count;
    logic [7:0]          r_checksum;
    logic                r_err_oor;

    logic                w_addr_in_range;
    logic                w_is_cmd;
    logic                w_is_data;
    logic                w_is_oor;
    logic                w_cmd_halt;
    logic                w_cmd_run;
    logic                w_cmd_clear;
    logic                w_core_gnt;
    logic                w_wr_en;
    logic [3:0]          w_wr_we;
    logic [MEM_AW-1:0]   w_wr_addr;
    logic [31:0]         w_wr_data;

    // Data bytes must have every address bit above the BRAM window clear.
    assign w_addr_in_range = (cfg_addr[23:MEM_AW+2] == {HI_W{1'b0}});

    // Classify the current config byte as command, data or out-of-range.
    always_comb begin
        w_is_cmd  = 1'b0;
        w_is_data = 1'b0;
        w_is_oor  = 1'b0;
        if (cfg_wr_en) begin
            if (cfg_addr == CMD_ADDR) begin
                w_is_cmd = 1'b1;
            end else if (w_addr_in_range) begin
                w_is_data = 1'b1;
            end else begin
                w_is_oor = 1'b1;
            end
        end else begin
            w_is_cmd  = 1'b0;
            w_is_data = 1'b0;
            w_is_oor  = 1'b0;
        end
    end

    // Decode the command opcode carried in the data byte.
    always_comb begin
        w_cmd_halt  = 1'b0;
        w_cmd_run   = 1'b0;
        w_cmd_clear = 1'b0;
        if (w_is_cmd) begin
            case (cfg_din)
                CMD_HALT:  w_cmd_halt  = 1'b1;
                CMD_RUN:   w_cmd_run   = 1'b1;
                CMD_CLEAR: w_cmd_clear = 1'b1;
                default: begin
                    w_cmd_halt  = 1'b0;
                    w_cmd_run   = 1'b0;
                    w_cmd_clear = 1'b0;
                end
            endcase
        end else begin
            w_cmd_halt  = 1'b0;
            w_cmd_run   = 1'b0;
            w_cmd_clear = 1'b0;
        end
    end

    // Any config activity, even a command or dropped byte, blocks the core.
    assign w_core_gnt = core_req & (r_state == ST_RUN) & ~cfg_wr_en;
    assign core_gnt   = w_core_gnt;

    // Select the write for this cycle: config data first, then core store.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_we   = 4'b0000;
        w_wr_addr = core_addr;
        w_wr_data = core_wdata;
        if (w_is_data) begin
            w_wr_en   = 1'b1;
            w_wr_we   = lane_decode(cfg_addr[1:0]);
            w_wr_addr = cfg_addr[MEM_AW+1:2];
            w_wr_data = {4{cfg_din}};
        end else if (w_core_gnt) begin
            w_wr_en   = 1'b1;
            w_wr_we   = core_wstrb;
            w_wr_addr = core_addr;
            w_wr_data = core_wdata;
        end else begin
            w_wr_en   = 1'b0;
            w_wr_we   = 4'b0000;
            w_wr_addr = core_addr;
            w_wr_data = core_wdata;
        end
    end

    // Register the BRAM port; address and data hold when idle.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            r_mem_addr  <= {MEM_AW{1'b0}};
            r_mem_wdata <= 32'h0000_0000;
        end else if (w_wr_en) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_wr_we;
            r_mem_addr  <= w_wr_addr;
            r_mem_wdata <= w_wr_data;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
        end
    end

    // Load statistics; CLEAR wins over any update in the same cycle.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_count <= 24'h000000;
            r_checksum   <= 8'h00;
            r_err_oor    <= 1'b0;
        end else if (w_cmd_clear) begin
            r_byte_count <= 24'h000000;
            r_checksum   <= 8'h00;
            r_err_oor    <= 1'b0;
        end else begin
            if (w_is_data) begin
                r_byte_count <= sat_inc24(r_byte_count);
                r_checksum   <= r_checksum + cfg_din;
            end else begin
                r_byte_count <= r_byte_count;
                r_checksum   <= r_checksum;
            end
            if (w_is_oor) begin
                r_err_oor <= 1'b1;
            end else begin
                r_err_oor <= r_err_oor;
            end
        end
    end

    // Core reset sequencer with registered core_rst_n / load_busy.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_HALT;
            r_hold_cnt   <= {HOLD_W{1'b0}};
            r_core_rst_n <= 1'b0;
            r_load_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_HALT: begin
                    r_core_rst_n <= 1'b0;
                    r_load_busy  <= 1'b1;
                    if (w_cmd_run) begin
                        r_state    <= ST_RELEASE;
                        r_hold_cnt <= {HOLD_W{1'b0}};
                    end else begin
                        r_state    <= ST_HALT;
                    end
                end
                ST_RELEASE: begin
                    if (w_cmd_halt) begin
                        r_state      <= ST_HALT;
                        r_core_rst_n <= 1'b0;
                        r_load_busy  <= 1'b1;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= ST_RUN;
                        r_core_rst_n <= 1'b1;
                        r_load_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt   <= r_hold_cnt + HOLD_W'(1);
                        r_core_rst_n <= 1'b0;
                        r_load_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_cmd_halt) begin
                        r_state      <= ST_HALT;
                        r_core_rst_n <= 1'b0;
                        r_load_busy  <= 1'b1;
                    end else begin
                        r_core_rst_n <= 1'b1;
                        r_load_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_HALT;
                    r_hold_cnt   <= {HOLD_W{1'b0}};
                    r_core_rst_n <= 1'b0;
                    r_load_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign load_busy  = r_load_busy;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign byte_count = r_byte_count;
    assign checksum   = r_checksum;
    assign err_oor    = r_err_oor;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Self-checking bench for instr_load_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the spec.

module tb_instr_load_ctrl;

    localparam int MEM_AW   = 14;
    localparam int RST_HOLD = 16;
    localparam int M_HALT = 0, M_REL = 1, M_RUN = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_wr_en;
    logic [23:0]       cfg_addr;
    logic [7:0]        cfg_din;
    logic              core_req;
    logic [MEM_AW-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic [3:0]        core_wstrb;
    logic              core_gnt;
    logic              core_rst_n;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              load_busy;
    logic [23:0]       byte_count;
    logic [7:0]        checksum;
    logic              err_oor;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int                m_state;
    longint            m_cyc;
    longint            m_rel_at;
    logic              m_en;
    logic [3:0]        m_we;
    logic [MEM_AW-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [23:0]       m_bc;
    logic [7:0]        m_cs;
    logic              m_oor;
    logic              exp_gnt;
    logic              obs_gnt;

    instr_load_ctrl #(.MEM_AW(MEM_AW), .CMD_ADDR(24'hFFFFFF), .RST_HOLD(RST_HOLD)) dut (
        .clk_user(clk), .reset_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
        .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wstrb(core_wstrb), .core_gnt(core_gnt), .core_rst_n(core_rst_n),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_busy(load_busy), .byte_count(byte_count), .checksum(checksum),
        .err_oor(err_oor)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = M_HALT; m_cyc = 0; m_rel_at = 0;
        m_en = 1'b0; m_we = 4'h0; m_addr = '0; m_wdata = 32'h0;
        m_bc = 24'h0; m_cs = 8'h0; m_oor = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one clock and step the model.
    task automatic drive(input logic en, input logic [23:0] a, input logic [7:0] d,
                         input logic req, input logic [MEM_AW-1:0] ca,
                         input logic [31:0] cw, input logic [3:0] cs);
        logic is_cmd, is_data, is_oor;
        cfg_wr_en = en; cfg_addr = a; cfg_din = d;
        core_req = req; core_addr = ca; core_wdata = cw; core_wstrb = cs;
        #1;
        exp_gnt = req && (m_state == M_RUN) && !en;
        obs_gnt = core_gnt;
        @(posedge clk);
        is_cmd  = en && (a == 24'hFFFFFF);
        is_data = en && !is_cmd && (a < 24'h010000);
        is_oor  = en && !is_cmd && !is_data;
        if (is_data) begin
            m_en = 1'b1; m_we = 4'(1 << (a % 4)); m_addr = MEM_AW'(a / 4); m_wdata = {4{d}};
        end else if (exp_gnt) begin
            m_en = 1'b1; m_we = cs; m_addr = ca; m_wdata = cw;
        end else begin
            m_en = 1'b0; m_we = 4'h0;
        end
        if (is_cmd && d == 8'h03) begin
            m_bc = 24'h0; m_cs = 8'h0; m_oor = 1'b0;
        end else begin
            if (is_data) begin
                if (m_bc != 24'hFFFFFF) m_bc = m_bc + 24'd1;
                m_cs = m_cs + d;
            end
            if (is_oor) m_oor = 1'b1;
        end
        if (is_cmd && d == 8'h01) m_state = M_HALT;
        else if (is_cmd && d == 8'h02 && m_state == M_HALT) begin
            m_state = M_REL; m_rel_at = m_cyc + 1 + RST_HOLD;
        end
        m_cyc++;
        if (m_state == M_REL && m_cyc >= m_rel_at) m_state = M_RUN;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 8'h0, 1'b0, '0, 32'h0, 4'h0);
    endtask

    task automatic apply_reset();
        cfg_wr_en = 1'b0; core_req = 1'b0; rst_n = 1'b0;
        #1; model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [88:0] obs, exp;
        cfg_wr_en = 1'b0; cfg_addr = 24'h0; cfg_din = 8'h0;
        core_addr = '0; core_wdata = 32'h0; core_wstrb = 4'h0;
        apply_reset();
        obs = {mem_en, mem_we, mem_addr, mem_wdata, byte_count, checksum, err_oor, core_rst_n, load_busy};
        exp = {1'b0, 4'h0, 14'h0, 32'h0, 24'h0, 8'h0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++; $display("FAIL reset_values got=%h exp=%h", obs, exp);
        end
        core_req = 1'b1; #1;
        checks++;
        if (core_gnt !== 1'b0) begin
            failures++; $display("FAIL reset_gnt got=%b exp=0", core_gnt);
        end
        core_req = 1'b0;
    endtask

    task automatic test_load_bytes();
        logic [7:0] lb [4];
        logic [3:0] lw [4];
        lb = '{8'h11, 8'h22, 8'h33, 8'h44};
        lw = '{4'h1, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 24'(i), lb[i], 1'b0, '0, 32'h0, 4'h0);
            checks++;
            if (mem_en !== 1'b1 || mem_we !== lw[i] || mem_addr !== 14'h0 || mem_wdata !== {4{lb[i]}}) begin
                failures++;
                $display("FAIL load_write%0d got en=%b we=%h addr=%h wd=%h exp en=1 we=%h addr=0 wd=%h",
                         i, mem_en, mem_we, mem_addr, mem_wdata, lw[i], {4{lb[i]}});
            end
            checks++;
            if (core_rst_n !== 1'b0) begin
                failures++; $display("FAIL load_core_rst got=%b exp=0", core_rst_n);
            end
        end
        idle(1);
        checks++;
        if (byte_count !== 24'd4 || checksum !== 8'hAA || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL load_stats got count=%0d sum=%h en=%b exp count=4 sum=aa en=0", byte_count, checksum, mem_en);
        end
    endtask

    task automatic test_run_cmd();
        int n;
        drive(1'b1, 24'hFFFFFF, 8'h02, 1'b0, '0, 32'h0, 4'h0);
        checks++;
        if (core_rst_n !== 1'b0 || load_busy !== 1'b1) begin
            failures++; $display("FAIL release_entry got rst_n=%b busy=%b exp 0/1", core_rst_n, load_busy);
        end
        n = 1;
        while (core_rst_n !== 1'b1 && n < 100) begin
            idle(1); n++;
        end
        checks++;
        if (n != RST_HOLD + 1) begin
            failures++; $display("FAIL release_latency got=%0d exp=%0d", n, RST_HOLD + 1);
        end
        checks++;
        if (load_busy !== 1'b0) begin
            failures++; $display("FAIL run_busy got=%b exp=0", load_busy);
        end
        drive(1'b1, 24'hFFFFFF, 8'h02, 1'b0, '0, 32'h0, 4'h0);
        idle(3);
        checks++;
        if (core_rst_n !== 1'b1 || load_busy !== 1'b0) begin
            failures++; $display("FAIL second_run got rst_n=%b busy=%b exp 1/0", core_rst_n, load_busy);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] cw;
        logic [23:0] a;
        logic [7:0]  d;
        cw = $urandom;
        for (int k = 0; k < 3; k++) begin
            a = 24'($urandom_range(0, 65535));
            d = 8'($urandom);
            drive(1'b1, a, d, 1'b1, 14'd5, cw, 4'hF);
            checks++;
            if (obs_gnt !== 1'b0) begin
                failures++; $display("FAIL arb_block%0d gnt got=%b exp=0", k, obs_gnt);
            end
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 4'(1 << (a % 4)) || mem_addr !== MEM_AW'(a / 4) || mem_wdata !== {4{d}}) begin
                failures++;
                $display("FAIL arb_cfg%0d got we=%h addr=%h wd=%h exp we=%h addr=%h wd=%h",
                         k, mem_we, mem_addr, mem_wdata, 4'(1 << (a % 4)), MEM_AW'(a / 4), {4{d}});
            end
        end
        drive(1'b0, 24'h0, 8'h0, 1'b1, 14'd5, cw, 4'hF);
        checks++;
        if (obs_gnt !== 1'b1) begin
            failures++; $display("FAIL arb_grant gnt got=%b exp=1", obs_gnt);
        end
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 4'hF || mem_addr !== 14'd5 || mem_wdata !== cw) begin
            failures++;
            $display("FAIL arb_core got en=%b we=%h addr=%h wd=%h exp 1/f/5/%h", mem_en, mem_we, mem_addr, mem_wdata, cw);
        end
        idle(1);
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 14'd5 || mem_wdata !== cw) begin
            failures++;
            $display("FAIL arb_idle got en=%b we=%h addr=%h wd=%h exp 0/0/5/%h", mem_en, mem_we, mem_addr, mem_wdata, cw);
        end
    endtask

    task automatic test_halt();
        int bad;
        drive(1'b1, 24'hFFFFFF, 8'h01, 1'b0, '0, 32'h0, 4'h0);
        checks++;
        if (core_rst_n !== 1'b0 || load_busy !== 1'b1) begin
            failures++; $display("FAIL halt_in_run got rst_n=%b busy=%b exp 0/1", core_rst_n, load_busy);
        end
        drive(1'b1, 24'hFFFFFF, 8'h02, 1'b0, '0, 32'h0, 4'h0);
        idle(5);
        drive(1'b1, 24'hFFFFFF, 8'h01, 1'b0, '0, 32'h0, 4'h0);
        checks++;
        if (core_rst_n !== 1'b0 || load_busy !== 1'b1) begin
            failures++; $display("FAIL halt_in_release got rst_n=%b busy=%b exp 0/1", core_rst_n, load_busy);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            drive(1'b0, 24'h0, 8'h0, 1'b1, 14'd9, 32'hDEAD_BEEF, 4'hF);
            if (obs_gnt !== 1'b0 || core_rst_n !== 1'b0 || mem_en !== 1'b0) bad++;
        end
        core_req = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL halt_no_grant bad_cycles got=%0d exp=0", bad);
        end
    endtask

    task automatic test_oor();
        logic [23:0] bc0;
        bc0 = byte_count;
        drive(1'b1, 24'h100000, 8'($urandom), 1'b0, '0, 32'h0, 4'h0);
        checks++;
        if (mem_en !== 1'b0 || err_oor !== 1'b1 || byte_count !== bc0) begin
            failures++;
            $display("FAIL oor got en=%b err=%b count=%0d exp en=0 err=1 count=%0d", mem_en, err_oor, byte_count, bc0);
        end
        drive(1'b1, 24'hFFFFFF, 8'h03, 1'b0, '0, 32'h0, 4'h0);
        checks++;
        if (err_oor !== 1'b0 || byte_count !== 24'h0 || checksum !== 8'h0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL clear got err=%b count=%0d sum=%h en=%b exp 0/0/0/0", err_oor, byte_count, checksum, mem_en);
        end
    endtask

    task automatic test_random();
        logic              pend;
        logic [MEM_AW-1:0] pa;
        logic [31:0]       pw;
        logic [3:0]        ps;
        logic              en;
        logic [23:0]       a;
        logic [7:0]        d;
        int                kind;
        int                bad_gnt, bad_mem, bad_stat, bad_state;
        pend = 1'b0; pa = '0; pw = 32'h0; ps = 4'h0;
        bad_gnt = 0; bad_mem = 0; bad_stat = 0; bad_state = 0;
        drive(1'b1, 24'hFFFFFF, 8'h02, 1'b0, '0, 32'h0, 4'h0);
        for (int i = 0; i < 600; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1; pa = MEM_AW'($urandom); pw = $urandom; ps = 4'($urandom);
            end
            en = ($urandom_range(0, 9) < 4);
            kind = $urandom_range(0, 19);
            d = 8'($urandom);
            if (kind < 14) a = 24'($urandom_range(0, 65535));
            else if (kind < 16) a = 24'($urandom_range(65536, 24'hFFFFFE));
            else begin
                a = 24'hFFFFFF;
                if (kind == 16) d = 8'h01;
                else if (kind == 17) d = 8'h02;
                else if (kind == 18) d = 8'h03;
            end
            drive(en, a, d, pend, pa, pw, ps);
            if (obs_gnt !== exp_gnt) begin
                bad_gnt++;
                if (bad_gnt < 4) $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", i, obs_gnt, exp_gnt);
            end
            if (mem_en !== m_en || mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
                bad_mem++;
                if (bad_mem < 4)
                    $display("FAIL rand_mem cyc=%0d got %b/%h/%h/%h exp %b/%h/%h/%h", i,
                             mem_en, mem_we, mem_addr, mem_wdata, m_en, m_we, m_addr, m_wdata);
            end
            if (byte_count !== m_bc || checksum !== m_cs || err_oor !== m_oor) begin
                bad_stat++;
                if (bad_stat < 4)
                    $display("FAIL rand_stats cyc=%0d got %0d/%h/%b exp %0d/%h/%b", i,
                             byte_count, checksum, err_oor, m_bc, m_cs, m_oor);
            end
            if (core_rst_n !== (m_state == M_RUN) || load_busy !== (m_state != M_RUN)) begin
                bad_state++;
                if (bad_state < 4)
                    $display("FAIL rand_state cyc=%0d got rst_n=%b busy=%b model_state=%0d", i, core_rst_n, load_busy, m_state);
            end
            if (pend && obs_gnt) pend = 1'b0;
        end
        checks++; if (bad_gnt != 0)   begin failures++; $display("FAIL rand_gnt_total got=%0d exp=0", bad_gnt); end
        checks++; if (bad_mem != 0)   begin failures++; $display("FAIL rand_mem_total got=%0d exp=0", bad_mem); end
        checks++; if (bad_stat != 0)  begin failures++; $display("FAIL rand_stats_total got=%0d exp=0", bad_stat); end
        checks++; if (bad_state != 0) begin failures++; $display("FAIL rand_state_total got=%0d exp=0", bad_state); end
    endtask

    task automatic test_reset_midrun();
        logic [88:0] obs, exp;
        int n;
        drive(1'b1, 24'hFFFFFF, 8'h01, 1'b0, '0, 32'h0, 4'h0);
        drive(1'b1, 24'hFFFFFF, 8'h02, 1'b0, '0, 32'h0, 4'h0);
        n = 0;
        while (core_rst_n !== 1'b1 && n < 40) begin idle(1); n++; end
        checks++;
        if (core_rst_n !== 1'b1) begin
            failures++; $display("FAIL midrun_reach_run rst_n got=%b exp=1", core_rst_n);
        end
        drive(1'b1, 24'h000123, 8'h5A, 1'b1, 14'd7, 32'h1234_5678, 4'h3);
        drive(1'b0, 24'h0, 8'h0, 1'b1, 14'd7, 32'h1234_5678, 4'h3);
        drive(1'b1, 24'h000456, 8'hC3, 1'b1, 14'd8, 32'hCAFE_F00D, 4'hF);
        rst_n = 1'b0;
        #1;
        exp = {1'b0, 4'h0, 14'h0, 32'h0, 24'h0, 8'h0, 1'b0, 1'b0, 1'b1};
        obs = {mem_en, mem_we, mem_addr, mem_wdata, byte_count, checksum, err_oor, core_rst_n, load_busy};
        checks++;
        if (obs !== exp) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp);
        end
        model_reset();
        @(posedge clk); #1;
        cfg_wr_en = 1'b0; core_req = 1'b0;
        rst_n = 1'b1;
        idle(2);
        obs = {mem_en, mem_we, mem_addr, mem_wdata, byte_count, checksum, err_oor, core_rst_n, load_busy};
        checks++;
        if (obs !== exp) begin
            failures++; $display("FAIL post_reset_halt got=%h exp=%h", obs, exp);
        end
        drive(1'b0, 24'h0, 8'h0, 1'b1, 14'd1, 32'h0, 4'hF);
        checks++;
        if (obs_gnt !== 1'b0) begin
            failures++; $display("FAIL post_reset_gnt got=%b exp=0", obs_gnt);
        end
        core_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_load_bytes();
        test_run_cmd();
        test_arbitration();
        test_halt();
        test_oor();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
